// File: rtl/fp32_to_int32_pipe.sv
// fp32_to_int32_pipe: three-stage elastic pipeline converting an IEEE-754 single-precision
// operand into a saturated two's-complement 32-bit integer, one conversion per clock.
//
// Ports:
//   CLK        clock, all state on rising edge
//   RST        synchronous active-high reset; clears all stage valids, OUT and FLG
//   IN_VALID   INA holds a valid operand
//   IN_READY   stage 1 can load this cycle (combinational through the ready chain)
//   INA        FP32 operand {sign, exp[7:0], frac[22:0]}
//   OUT_VALID  OUT/FLG hold a valid result
//   OUT_READY  downstream accepts this cycle
//   OUT        signed integer result
//   FLG        {NV, OF, NX, ZR}: NaN input, overflow/infinity, inexact, result zero
//
// Build option:
//   FP2INT_ROUND_NEAREST_EN  defined: round to nearest, ties to even
//                            undefined: truncate toward zero (NX still reported)
module fp32_to_int32_pipe #(
  parameter int unsigned OFST = 127
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] INA,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] OUT,
  output logic [3:0]  FLG
);

  // Pipeline valids and load enables
  logic v1_q, v2_q, v3_q;
  logic ld1, ld2, ld3;

  assign ld3      = ~v3_q | OUT_READY;
  assign ld2      = ~v2_q | ld3;
  assign ld1      = ~v1_q | ld2;
  assign IN_READY = ld1 & ~RST;

  // Stage 1: decode
  logic        s1_sign_q;
  logic [7:0]  s1_exp_q;
  logic [23:0] s1_sig_q;
  logic        s1_zd_q, s1_inf_q, s1_nan_q;

  always_ff @(posedge CLK) begin
    if (ld1 && IN_VALID) begin
      s1_sign_q <= INA[31];
      s1_exp_q  <= INA[30:23];
      s1_sig_q  <= {(INA[30:23] != 8'h00), INA[22:0]};
      s1_zd_q   <= (INA[30:23] == 8'h00);
      s1_inf_q  <= (INA[30:23] == 8'hFF) && (INA[22:0] == 23'd0);
      s1_nan_q  <= (INA[30:23] == 8'hFF) && (INA[22:0] != 23'd0);
    end
  end

  // Stage 2: align
  logic signed [9:0] e;
  logic [54:0]       wide;
  logic [31:0]       al_mag;
  logic              al_guard, al_sticky, al_ovf;

  assign e    = $signed({2'b00, s1_exp_q}) - $signed(10'(OFST));
  assign wide = 55'(s1_sig_q) << e[4:0];

  always_comb begin
    al_mag    = 32'd0;
    al_guard  = 1'b0;
    al_sticky = 1'b0;
    al_ovf    = 1'b0;
    if (s1_zd_q) begin
      al_sticky = |s1_sig_q[22:0];
    end else if (e[9]) begin
      if (e == -10'sd1) begin
        al_guard  = s1_sig_q[23];
        al_sticky = |s1_sig_q[22:0];
      end else begin
        al_sticky = |s1_sig_q;
      end
    end else if (e <= 10'sd30) begin
      al_mag    = wide[54:23];
      al_guard  = wide[22];
      al_sticky = |wide[21:0];
    end else if (s1_sign_q && (e == 10'sd31) && (s1_sig_q[22:0] == 23'd0)) begin
      // -2^31 is the only representable value with e >= 31
      al_mag = 32'h8000_0000;
    end else begin
      al_ovf = 1'b1;
    end
  end

  logic        s2_sign_q;
  logic [31:0] s2_mag_q;
  logic        s2_guard_q, s2_sticky_q, s2_ovf_q, s2_inf_q, s2_nan_q;

  always_ff @(posedge CLK) begin
    if (ld2 && v1_q) begin
      s2_sign_q   <= s1_sign_q;
      s2_mag_q    <= al_mag;
      s2_guard_q  <= al_guard;
      s2_sticky_q <= al_sticky;
      s2_ovf_q    <= al_ovf;
      s2_inf_q    <= s1_inf_q;
      s2_nan_q    <= s1_nan_q;
    end
  end

  // Stage 3: round, sign, saturate
  logic        inc;
  logic [32:0] mag_r;
  logic        sat;
  logic [31:0] res;
  logic        nv, of, nx, zr;
  logic [31:0] out_d;

`ifdef FP2INT_ROUND_NEAREST_EN
  assign inc = s2_guard_q & (s2_mag_q[0] | s2_sticky_q);
`else
  assign inc = 1'b0;
`endif

  always_comb begin
    mag_r = {1'b0, s2_mag_q} + 33'(inc);
    sat   = s2_sign_q ? (mag_r > 33'h0_8000_0000) : (mag_r > 33'h0_7FFF_FFFF);
    res   = s2_sign_q ? (32'd0 - mag_r[31:0]) : mag_r[31:0];
    nv    = s2_nan_q;
    of    = ~s2_nan_q & (s2_inf_q | s2_ovf_q | sat);
    if (nv) begin
      out_d = 32'h7FFF_FFFF;
    end else if (of) begin
      out_d = s2_sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      out_d = res;
    end
    nx = (s2_guard_q | s2_sticky_q) & ~nv & ~of;
    zr = (out_d == 32'd0) & ~nv & ~of;
  end

  logic [31:0] out_q;
  logic [3:0]  flg_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      out_q <= 32'd0;
      flg_q <= 4'd0;
    end else begin
      if (ld1) v1_q <= IN_VALID;
      if (ld2) v2_q <= v1_q;
      if (ld3) begin
        v3_q <= v2_q;
        // Data only moves with a real result so OUT stays put across bubbles
        if (v2_q) begin
          out_q <= out_d;
          flg_q <= {nv, of, nx, zr};
        end
      end
    end
  end

  assign OUT_VALID = v3_q;
  assign OUT       = out_q;
  assign FLG       = flg_q;

endmodule

// File: tb/tb_fp32_to_int32_pipe.sv
module tb_fp32_to_int32_pipe;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] INA;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT;
  logic [3:0]  FLG;

  fp32_to_int32_pipe dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .INA       (INA),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT       (OUT),
    .FLG       (FLG)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;

  logic [35:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  // Scoreboard: every transfer out must match the oldest expected result
  logic        prev_stall = 1'b0;
  logic [31:0] prev_out;
  logic [3:0]  prev_flg;

  always @(negedge CLK) begin
    if (prev_stall && !RST) begin
      check_eq("hold_stable", {3'b0, OUT_VALID, OUT, FLG}, {3'b0, 1'b1, prev_out, prev_flg});
    end
    if (OUT_VALID && OUT_READY && !RST) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_out", {4'b0, OUT, FLG}, 40'hFF_FFFF_FFFF);
      end else begin
        check_eq("result", {4'b0, OUT, FLG}, {4'b0, exp_q.pop_front()});
      end
    end
    prev_stall = OUT_VALID && !OUT_READY && !RST;
    prev_out   = OUT;
    prev_flg   = FLG;
  end

  task automatic send(input logic [31:0] a, input logic [31:0] eo, input logic [3:0] ef);
    int k;
    IN_VALID = 1'b1;
    INA      = a;
    k = 0;
    @(negedge CLK);
    while (!IN_READY && k < 100) begin
      @(negedge CLK);
      k++;
    end
    if (k >= 100) check_eq("send_timeout", 40'd0, 40'd1);
    exp_q.push_back({eo, ef});
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      @(posedge CLK);
      #1;
      k++;
    end
    check_eq("drain_empty", 40'(exp_q.size()), 40'd0);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] o;
    logic [3:0]  f;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    RST       = 1'b1;
    IN_VALID  = 1'b0;
    INA       = 32'd0;
    OUT_READY = 1'b1;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check_eq("rst_out_valid", 40'(OUT_VALID), 40'd0);
    check_eq("rst_out", 40'(OUT), 40'd0);
    check_eq("rst_flg", 40'(FLG), 40'd0);
    check_eq("rst_in_ready", 40'(IN_READY), 40'd0);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    check_eq("in_ready_after_rst", 40'(IN_READY), 40'd1);

    // Directed vectors, one per cycle
`ifdef FP2INT_ROUND_NEAREST_EN
    vecs.push_back('{32'h3FC0_0000, 32'h0000_0002, 4'b0010});
    vecs.push_back('{32'hC060_0000, 32'hFFFF_FFFC, 4'b0010});
`else
    vecs.push_back('{32'h3FC0_0000, 32'h0000_0001, 4'b0010});
    vecs.push_back('{32'hC060_0000, 32'hFFFF_FFFD, 4'b0010});
`endif
    vecs.push_back('{32'h4020_0000, 32'h0000_0002, 4'b0010});
    vecs.push_back('{32'h42F6_0000, 32'h0000_007B, 4'b0000});
    vecs.push_back('{32'h4F00_0000, 32'h7FFF_FFFF, 4'b0100});
    vecs.push_back('{32'hCF00_0000, 32'h8000_0000, 4'b0000});
    vecs.push_back('{32'hFF80_0000, 32'h8000_0000, 4'b0100});
    vecs.push_back('{32'h7F80_0000, 32'h7FFF_FFFF, 4'b0100});
    vecs.push_back('{32'h7FC0_0000, 32'h7FFF_FFFF, 4'b1000});
    vecs.push_back('{32'h0000_0001, 32'h0000_0000, 4'b0011});
    vecs.push_back('{32'h8000_0000, 32'h0000_0000, 4'b0001});
    vecs.push_back('{32'h3E80_0000, 32'h0000_0000, 4'b0011});
    vecs.push_back('{32'hBF80_0000, 32'hFFFF_FFFF, 4'b0000});
    vecs.push_back('{32'h4EFF_FFFF, 32'h7FFF_FF80, 4'b0000});
    foreach (vecs[i]) send(vecs[i].a, vecs[i].o, vecs[i].f);
    drain();

    // Backpressure: stall 5 cycles from first OUT_VALID
    base = n_out;
    fork
      begin
        send(32'h3F80_0000, 32'd1, 4'b0000);
        send(32'h4000_0000, 32'd2, 4'b0000);
        send(32'h4040_0000, 32'd3, 4'b0000);
        send(32'h4080_0000, 32'd4, 4'b0000);
        send(32'h40A0_0000, 32'd5, 4'b0000);
        send(32'h40C0_0000, 32'd6, 4'b0000);
      end
      begin
        int k = 0;
        while (!OUT_VALID && k < 50) begin
          @(posedge CLK);
          #1;
          k++;
        end
        check_eq("bp_first_valid", 40'(OUT_VALID), 40'd1);
        OUT_READY = 1'b0;
        #1;
        check_eq("bp_full_in_ready", 40'(IN_READY), 40'd0);
        repeat (5) @(posedge CLK);
        #1;
        OUT_READY = 1'b1;
      end
    join
    drain();
    check_eq("bp_count", 40'(n_out - base), 40'd6);

    // Reset with two operands in flight
    base = n_out;
    send(32'h40A0_0000, 32'd5, 4'b0000);
    send(32'h40C0_0000, 32'd6, 4'b0000);
    RST = 1'b1;
    exp_q.delete();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    repeat (4) begin
      @(posedge CLK);
      #1;
      check_eq("post_rst_valid", {7'b0, OUT_VALID, OUT}, 40'd0);
    end
    check_eq("post_rst_count", 40'(n_out - base), 40'd0);

    // Latency: accept at edge t, result visible after edge t+2
    IN_VALID = 1'b1;
    INA      = 32'h4040_0000;
    @(negedge CLK);
    check_eq("lat_in_ready", 40'(IN_READY), 40'd1);
    exp_q.push_back({32'd3, 4'b0000});
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    check_eq("lat_t0", 40'(OUT_VALID), 40'd0);
    @(posedge CLK);
    #1;
    check_eq("lat_t1", 40'(OUT_VALID), 40'd0);
    @(posedge CLK);
    #1;
    check_eq("lat_t2", {7'b0, OUT_VALID, OUT}, {7'b0, 1'b1, 32'd3});
    drain();

    repeat (2) @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp32_to_int32_pipe.md
# fp32_to_int32_pipe

Pipelined converter from IEEE-754 single-precision to two's-complement signed 32-bit integer. It is the exit point of the FP32 datapath: results of the combinational add/sub/mul/div units leave the float domain here toward integer consumers. The block is three register stages deep with valid/ready flow control on both sides and sustains one conversion per clock. It saturates out-of-range inputs and reports status flags.

## Interface
- OFST, 127, exponent bias.
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  reset, synchronous, active-high.
- IN_VALID  in  1  INA holds a valid operand.
- IN_READY  out  1  stage 1 can load this cycle.
- INA  in  32  FP32 operand {sign, exp[7:0], frac[22:0]}.
- OUT_VALID  out  1  OUT/FLG hold a valid result.
- OUT_READY  in  1  downstream accepts this cycle.
- OUT  out  32  signed integer result.
- FLG  out  4  {NV, OF, NX, ZR}: NaN input, overflow/infinity, inexact, result zero.

## Operation
- Transfer in: IN_VALID & IN_READY at an edge. Transfer out: OUT_VALID & OUT_READY at an edge.
- Stage 1 (decode): register sign, exp, and significand {~exp00, frac}. Register class bits: exp==00 (zero/denormal), exp==FF & frac==0 (inf), exp==FF & frac!=0 (NaN).
- Stage 2 (align): e = exp - OFST, computed in 10 bits signed.
  - e<0: magnitude = 0; guard = (e==-1) ? hidden bit : 0; sticky = OR of remaining significand bits.
  - 0<=e<=30: magnitude = sig24 << e >> 23; guard = first bit shifted out; sticky = OR of all lower bits.
  - e>=31: overflow candidate. Exception: sign=1, exp=158, frac=0 is exact -2^31.
  - Denormal inputs: magnitude 0, sticky = |frac.
- Stage 3 (round, sign, saturate): apply rounding increment (see Configuration), then negate if sign. Final magnitude >2^31-1 (positive) or >2^31 (negative) saturates.
- Result selection, in priority order:
  - NaN → 0x7FFFFFFF, NV=1.
  - ±inf or overflow → 0x7FFFFFFF / 0x80000000 by sign, OF=1.
  - Otherwise the rounded value.
- NX=1 when guard|sticky and neither NV nor OF. ZR=1 when OUT==0 and NV=OF=0. -0.0 yields 0x00000000.
- Elastic pipeline, no skid buffers:
  - Stage k loads when its valid is 0 or stage k+1 loads/outputs this cycle.
  - IN_READY = stage 1 loadable; this is combinational from OUT_READY through the ready chain.
  - Stage 3 holds OUT/FLG stable while OUT_VALID & ~OUT_READY.
- Ordering preserved; no drop or duplication under any IN_VALID/OUT_READY pattern.

## Timing
- Latency: operand accepted at edge t is in stage 3 after edge t+2. OUT_VALID is high in the following cycle when the pipeline is not stalled.
- Throughput: 1 per cycle with OUT_READY held high.
- Reset: while RST=1 at an edge, all stage valids clear. OUT=0, FLG=0, OUT_VALID=0 after that edge. IN_READY=0 while RST is high and 1 in the first cycle after.
- Reset mid-stream: in-flight operands are discarded and not emitted.
- Full stall: OUT_READY low with 3 results in flight → IN_READY low the same cycle.
- Simultaneous accept and emit with a full pipeline: all stages advance; IN_READY=1.
- OUT_VALID, once asserted, stays high with OUT unchanged until transfer out.

## Configuration
- FP2INT_ROUND_NEAREST_EN:
  - Defined: round to nearest, ties to even. Increment = guard & (lsb | sticky).
  - Undefined: truncate toward zero. Increment = 0; NX is still reported.
  - Pipeline depth, flags and saturation are the same in both builds.

## Test plan
- Rounding, one operand per cycle, OUT_READY=1:
  - 0x3FC00000 (1.5) → 2 with macro, 1 without; NX=1.
  - 0x40200000 (2.5) → 2 in both builds; NX=1.
  - 0xC0600000 (-3.5) → 0xFFFFFFFC with macro, 0xFFFFFFFD without.
  - 0x42F60000 (123.0) → 0x0000007B, FLG=0.
- Range limits:
  - 0x4F000000 (2^31) → 0x7FFFFFFF, OF=1.
  - 0xCF000000 (-2^31) → 0x80000000, FLG=0.
  - 0xFF800000 (-inf) → 0x80000000, OF=1.
  - 0x7FC00000 (NaN) → 0x7FFFFFFF, NV=1.
- Zero and denormal:
  - 0x00000001 → 0, FLG=0011.
  - 0x80000000 (-0.0) → 0, FLG=0001.
  - 0x3E800000 (0.25) → 0, ZR=1, NX=1.
- Backpressure: stream 6 operands 1..6 (0x3F800000…0x40C00000), OUT_READY low for 5 cycles starting at the first OUT_VALID.
  - IN_READY drops with 3 in flight.
  - Outputs are 1..6 in order, no loss or duplicates, OUT stable while stalled.
- Reset mid-stream: assert RST for 1 cycle with 2 operands in flight.
  - No stale OUT_VALID afterward; OUT=0.
  - Next operand 0x40400000 → 3 after 3 stages.
